memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 156 +++++++++++++++
 tb/tb_memory_access.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// MEM stage of a 5-stage RV32 pipeline: byte-addressable little-endian data memory
// with sized, sign/zero-extended loads, alignment checking and the MEM/WB register.
module memory_access #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic [31:0] alu_data_out,
  output logic [31:0] dm_data_out,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic        misaligned
);

  logic [31:0] mem [DEPTH_WORDS];

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           byte_off;
  logic [31:0]          old_word;
  logic                 is_half;
  logic                 is_word;
  logic                 fault;
  logic                 store_en;
  logic                 unused_addr_hi;

  logic [31:0] alu_data_d, alu_data_q;
  logic [31:0] dm_data_d, dm_data_q;
  logic        mem_to_reg_d, mem_to_reg_q;
  logic        reg_write_d, reg_write_q;
  logic [4:0]  rd_d, rd_q;
  logic        misaligned_d, misaligned_q;

  // Selects the addressed lane of a word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Merges store data into the addressed lanes, leaving the other lanes untouched.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] data,
                                              input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          default: r[31:24] = data[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = data[15:0];
        else        r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  assign word_idx       = alu_result[ADDR_BITS+1:2];
  assign byte_off       = alu_result[1:0];
  assign unused_addr_hi = ^alu_result[31:ADDR_BITS+2];
  assign old_word       = mem[word_idx];
  assign is_half        = (mem_size == 2'b01);
  assign is_word        = mem_size[1];
  assign fault          = (mem_read || mem_write) &&
                          ((is_half && byte_off[0]) || (is_word && byte_off != 2'b00));
  assign store_en       = mem_write && !fault && !stall && !flush && !rst;

  always_comb begin
    alu_data_d   = alu_data_q;
    dm_data_d    = dm_data_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    misaligned_d = misaligned_q;
    if (flush) begin
      alu_data_d   = '0;
      dm_data_d    = '0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      rd_d         = '0;
      misaligned_d = 1'b0;
    end else if (!stall) begin
      alu_data_d   = alu_result;
      dm_data_d    = (mem_read && !fault) ?
                     load_extend(old_word, byte_off, mem_size, mem_unsigned) : 32'd0;
      mem_to_reg_d = mem_to_reg_in;
      reg_write_d  = reg_write_in && !fault;
      rd_d         = rd_in;
      misaligned_d = fault;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_data_q   <= '0;
      dm_data_q    <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      alu_data_q   <= alu_data_d;
      dm_data_q    <= dm_data_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Load data above was taken from the pre-store word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (store_en) mem[word_idx] <= store_merge(old_word, store_data, byte_off, mem_size);
  end

  assign alu_data_out = alu_data_q;
  assign dm_data_out  = dm_data_q;
  assign mem_to_reg   = mem_to_reg_q;
  assign reg_write    = reg_write_q;
  assign rd           = rd_q;
  assign misaligned   = misaligned_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: loads, stores, alignment, stall/flush/reset.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_read, mem_write, mem_unsigned, mem_to_reg_in, reg_write_in;
  logic [1:0]  mem_size;
  logic [4:0]  rd_in;
  logic [31:0] alu_result, store_data;
  logic [31:0] alu_data_out, dm_data_out;
  logic        mem_to_reg, reg_write, misaligned;
  logic [4:0]  rd;

  int total  = 0;
  int passed = 0;

  memory_access #(.DEPTH_WORDS(256), .ADDR_BITS(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .rd_in(rd_in), .alu_result(alu_result),
    .store_data(store_data), .alu_data_out(alu_data_out), .dm_data_out(dm_data_out),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd(rd), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] data,
                       input logic rwi, input logic [4:0] rdi, input logic m2r);
    mem_read      = rd_en;
    mem_write     = wr_en;
    mem_size      = sz;
    mem_unsigned  = uns;
    alu_result    = addr;
    store_data    = data;
    reg_write_in  = rwi;
    rd_in         = rdi;
    mem_to_reg_in = m2r;
  endtask

  task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, 1'b1, 2'b10, 1'b0, addr, data, 1'b0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 1'b1, 5'd9, 1'b1);
    tick(); tick();
    total++; if (alu_data_out !== 32'h0) $display("FAIL reset_alu: got %h expected 0", alu_data_out); else passed++;
    total++; if (dm_data_out !== 32'h0) $display("FAIL reset_dm: got %h expected 0", dm_data_out); else passed++;
    total++; if (reg_write !== 1'b0) $display("FAIL reset_regwrite: got %b expected 0", reg_write); else passed++;
    total++; if (rd !== 5'd0) $display("FAIL reset_rd: got %0d expected 0", rd); else passed++;
    total++; if (mem_to_reg !== 1'b0) $display("FAIL reset_m2r: got %b expected 0", mem_to_reg); else passed++;
    total++; if (misaligned !== 1'b0) $display("FAIL reset_misaligned: got %b expected 0", misaligned); else passed++;
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 1'b1, 5'd3, 1'b0);
    tick();
    total++; if (alu_data_out !== 32'h8 || rd !== 5'd3) $display("FAIL post_reset_first: got alu %h rd %0d expected 8 / 3", alu_data_out, rd); else passed++;
  endtask

  task automatic test_word();
    store_word(32'h10, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 5'd5, 1'b1);
    tick();
    total++; if (dm_data_out !== 32'hDEAD_BEEF) $display("FAIL word_load: got %h expected deadbeef", dm_data_out); else passed++;
    total++; if (misaligned !== 1'b0) $display("FAIL word_misaligned: got %b expected 0", misaligned); else passed++;
    total++; if (reg_write !== 1'b1 || rd !== 5'd5 || mem_to_reg !== 1'b1) $display("FAIL word_ctrl: got rw %b rd %0d m2r %b expected 1/5/1", reg_write, rd, mem_to_reg); else passed++;
    total++; if (alu_data_out !== 32'h10) $display("FAIL word_alu: got %h expected 10", alu_data_out); else passed++;
  endtask

  task automatic test_load_extend();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b1, 5'd1, 1'b1); tick();
    total++; if (dm_data_out !== 32'hFFFF_FFDE) $display("FAIL lb_signed: got %h expected ffffffde", dm_data_out); else passed++;
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b1, 5'd1, 1'b1); tick();
    total++; if (dm_data_out !== 32'h0000_00DE) $display("FAIL lbu: got %h expected 000000de", dm_data_out); else passed++;
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b1, 5'd1, 1'b1); tick();
    total++; if (dm_data_out !== 32'hFFFF_DEAD) $display("FAIL lh_signed: got %h expected ffffdead", dm_data_out); else passed++;
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b1, 5'd1, 1'b1); tick();
    total++; if (dm_data_out !== 32'h0000_BEEF) $display("FAIL lhu_low: got %h expected 0000beef", dm_data_out); else passed++;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b1, 5'd1, 1'b1); tick();
    total++; if (dm_data_out !== 32'hFFFF_FFEF) $display("FAIL lb_lane0: got %h expected ffffffef", dm_data_out); else passed++;
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b1, 5'd1, 1'b1); tick();
    total++; if (dm_data_out !== 32'hDEAD_BEEF) $display("FAIL size11_word: got %h expected deadbeef", dm_data_out); else passed++;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 5'd1, 1'b0); tick();
    total++; if (dm_data_out !== 32'h0) $display("FAIL no_read_zero: got %h expected 0", dm_data_out); else passed++;
  endtask

  task automatic test_sub_word_store();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAABB_CC55, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 5'd2, 1'b1); tick();
    total++; if (dm_data_out !== 32'hDEAD_55EF) $display("FAIL sb_merge: got %h expected dead55ef", dm_data_out); else passed++;
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234, 1'b0, 5'd0, 1'b0); tick();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 5'd2, 1'b1); tick();
    total++; if (dm_data_out !== 32'h1234_55EF) $display("FAIL sh_merge: got %h expected 123455ef", dm_data_out); else passed++;
  endtask

  task automatic test_misaligned();
    store_word(32'h20, 32'hCAFE_F00D);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h1111_1111, 1'b1, 5'd6, 1'b0); tick();
    total++; if (misaligned !== 1'b1) $display("FAIL sw_misaligned_flag: got %b expected 1", misaligned); else passed++;
    total++; if (reg_write !== 1'b0) $display("FAIL sw_misaligned_rw: got %b expected 0", reg_write); else passed++;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 5'd6, 1'b1); tick();
    total++; if (misaligned !== 1'b0) $display("FAIL misaligned_one_cycle: got %b expected 0", misaligned); else passed++;
    total++; if (dm_data_out !== 32'hCAFE_F00D) $display("FAIL misaligned_no_store: got %h expected cafef00d", dm_data_out); else passed++;
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b1, 5'd6, 1'b1); tick();
    total++; if (misaligned !== 1'b1 || dm_data_out !== 32'h0 || reg_write !== 1'b0) $display("FAIL lh_misaligned: got mis %b dm %h rw %b expected 1/0/0", misaligned, dm_data_out, reg_write); else passed++;
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 1'b1, 5'd6, 1'b1); tick();
    total++; if (misaligned !== 1'b0 || dm_data_out !== 32'h0000_00F0) $display("FAIL lbu_odd: got mis %b dm %h expected 0/000000f0", misaligned, dm_data_out); else passed++;
  endtask

  task automatic test_back_to_back();
    store_word(32'h30, 32'h0102_0304);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hA5A5_A5A5, 1'b1, 5'd4, 1'b1); tick();
    total++; if (dm_data_out !== 32'h0102_0304) $display("FAIL read_before_write: got %h expected 01020304", dm_data_out); else passed++;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, 5'd4, 1'b1); tick();
    total++; if (dm_data_out !== 32'hA5A5_A5A5) $display("FAIL rbw_committed: got %h expected a5a5a5a5", dm_data_out); else passed++;
    store_word(32'h34, 32'h0BAD_F00D);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h34, 32'h0, 1'b1, 5'd4, 1'b1); tick();
    total++; if (dm_data_out !== 32'h0BAD_F00D) $display("FAIL store_then_load: got %h expected 0badf00d", dm_data_out); else passed++;
  endtask

  task automatic test_stall_flush();
    store_word(32'h38, 32'h8888_8888);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, 5'd7, 1'b1); tick();
    stall = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h38, 32'h7777_7777, 1'b0, 5'd12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dm_data_out !== 32'hA5A5_A5A5 || alu_data_out !== 32'h30 || rd !== 5'd7 || reg_write !== 1'b1 || mem_to_reg !== 1'b1)
        $display("FAIL stall_hold_%0d: got dm %h alu %h rd %0d rw %b m2r %b expected a5a5a5a5/30/7/1/1", i, dm_data_out, alu_data_out, rd, reg_write, mem_to_reg);
      else passed++;
    end
    stall = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h38, 32'h0, 1'b1, 5'd7, 1'b1); tick();
    total++; if (dm_data_out !== 32'h8888_8888) $display("FAIL stall_no_store: got %h expected 88888888", dm_data_out); else passed++;
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h38, 32'h9999_9999, 1'b1, 5'd8, 1'b1); tick();
    total++; if (dm_data_out !== 32'h0 || alu_data_out !== 32'h0 || rd !== 5'd0 || reg_write !== 1'b0 || mem_to_reg !== 1'b0 || misaligned !== 1'b0)
      $display("FAIL flush_bubble: got dm %h alu %h rd %0d rw %b m2r %b mis %b expected all 0", dm_data_out, alu_data_out, rd, reg_write, mem_to_reg, misaligned);
    else passed++;
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h38, 32'h0, 1'b1, 5'd8, 1'b1); tick();
    total++; if (dm_data_out !== 32'h8888_8888) $display("FAIL flush_no_store: got %h expected 88888888", dm_data_out); else passed++;
  endtask

  task automatic test_reset_store();
    store_word(32'h40, 32'h0F0F_0F0F);
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678, 1'b1, 5'd10, 1'b1); tick();
    total++; if (dm_data_out !== 32'h0 || alu_data_out !== 32'h0 || rd !== 5'd0 || reg_write !== 1'b0 || mem_to_reg !== 1'b0)
      $display("FAIL rst_during_store: got dm %h alu %h rd %0d rw %b m2r %b expected all 0", dm_data_out, alu_data_out, rd, reg_write, mem_to_reg);
    else passed++;
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 5'd10, 1'b1); tick();
    total++; if (dm_data_out !== 32'h0F0F_0F0F) $display("FAIL rst_no_store: got %h expected 0f0f0f0f", dm_data_out); else passed++;
  endtask

  task automatic test_alias();
    store_word(32'h410, 32'h600D_CAFE);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 5'd11, 1'b1); tick();
    total++; if (dm_data_out !== 32'h600D_CAFE) $display("FAIL alias_410: got %h expected 600dcafe", dm_data_out); else passed++;
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'hFFFF_F412, 32'h0, 1'b1, 5'd11, 1'b1); tick();
    total++; if (dm_data_out !== 32'h0000_600D) $display("FAIL alias_high_bits: got %h expected 0000600d", dm_data_out); else passed++;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1;
    test_reset();
    test_word();
    test_load_extend();
    test_sub_word_store();
    test_misaligned();
    test_back_to_back();
    test_stall_flush();
    test_reset_store();
    test_alias();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
